pci_mem_target: RTL and testbench
=================================

PCI_MEM_TARGET -- requirements
Module: pci_mem_target

Interface
REQ-001 Parameter BAR, default 28'h0000001, is the base address compared against AD[31:4]; the target claims 0x10-0x1F by default.
REQ-002 Parameter MEM_WORDS, fixed at 4, is the number of 32-bit registers, indexed by AD[3:2].
REQ-003 CLK  input  1  bus clock; all state changes on the rising edge.
REQ-004 RST_n  input  1  asynchronous, active-low reset.
REQ-005 FRAME_n  input  1  bus FRAME, active low.
REQ-006 IRDY_n  input  1  initiator ready, active low.
REQ-007 AD_IN  input  32  sampled address/data bus.
REQ-008 C_BE_n  input  4  command during the address phase; active-low byte enables during data phases.
REQ-009 AD_OUT  output  32  read data.
REQ-010 AD_OE  output  1  AD_OUT drive enable.
REQ-011 TRDY_n  output  1  target ready, active low.
REQ-012 DEVSEL_n  output  1  device select, active low.
REQ-013 CTL_OE  output  1  drive enable for TRDY_n and DEVSEL_n.

Function
REQ-014 The address phase is the first cycle with FRAME_n=0 while the bus was idle (FRAME_n=1 and IRDY_n=1) in the previous cycle.
REQ-015 The target claims the transaction only if, in the address phase, AD_IN[31:4]==BAR and C_BE_n is 4'b0110 (memory read) or 4'b0111 (memory write); otherwise it goes to BUSY.
REQ-016 States: IDLE, BUSY, WRITE, READ_TA, READ, TURN.
REQ-017 BUSY returns to IDLE on the first cycle with FRAME_n=1 and IRDY_n=1; the target drives nothing while in BUSY.
REQ-018 On a claimed address phase, latch the word index from AD_IN[3:2].
REQ-019 On a write claim: go to WRITE; CTL_OE=1, DEVSEL_n=0 and TRDY_n=0 starting the next cycle (fast decode, zero wait states).
REQ-020 On a read claim: go to READ_TA for one turnaround cycle with CTL_OE=1, DEVSEL_n=0, TRDY_n=1; then go to READ with AD_OE=1, TRDY_n=0 and AD_OUT=mem[index].
REQ-021 A data phase completes on a cycle with IRDY_n=0 and TRDY_n=0; IRDY_n=1 inserts initiator wait states and the target holds all outputs.
REQ-022 Write data phase: for each byte lane k with C_BE_n[k]=0, write AD_IN[8k+7:8k] into mem[index]; lanes with C_BE_n[k]=1 are left unchanged.
REQ-023 After each completed data phase, index increments modulo 4 (3 wraps to 0); for reads, AD_OUT presents the new word in the next cycle.
REQ-024 A completed data phase with FRAME_n=1 is the last phase: go to TURN.
REQ-025 TURN lasts one cycle with DEVSEL_n=1, TRDY_n=1, CTL_OE=1 and AD_OE=0; then IDLE with CTL_OE=0.
REQ-026 In IDLE, BUSY and TURN, AD_OE=0; in every state except READ, AD_OUT=0.
REQ-027 A new address phase seen during TURN is ignored; the target re-arms only from IDLE.

Reset
REQ-028 While RST_n=0: state=IDLE, AD_OE=0, CTL_OE=0, TRDY_n=1, DEVSEL_n=1, AD_OUT=0, index=0, and all mem words=0.
REQ-029 Reset asserted mid-transaction releases all drivers immediately (asynchronously); the first cycle after deassertion is IDLE and requires a fresh idle-to-FRAME_n transition before a claim.

Verification
REQ-030 Single write: address 0x14, cmd 0111, one data phase of 0xAAAAAAAA with BE 0000 and FRAME_n high -> DEVSEL_n/TRDY_n low the next cycle, mem[1]=0xAAAAAAAA, then one TURN cycle, then CTL_OE=0.
REQ-031 Partial write: address 0x10, BE 1100, data 0xBBBBBBBB -> mem[0]=0x0000BBBB after reset.
REQ-032 Burst read from 0x1C over 3 phases with one IRDY_n wait state on phase 2 -> one READ_TA cycle, then AD_OUT=mem[3], mem[0], mem[1]; the waited word is held for two cycles.
REQ-033 Miss: address 0x20 or cmd 1100 -> DEVSEL_n stays 1 and CTL_OE stays 0 throughout; the target claims the next valid transaction after the bus goes idle.
REQ-034 RST_n pulsed low during a burst write -> outputs released within the same cycle, and all mem words read back as 0 afterwards.

Source files
------------

// File: rtl/pci_mem_target.sv
// pci_mem_target: zero-wait-state PCI memory target exposing four 32-bit registers
module pci_mem_target #(
    parameter logic [27:0] BAR       = 28'h0000001,
    parameter int          MEM_WORDS = 4
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        FRAME_n,
    input  logic        IRDY_n,
    input  logic [31:0] AD_IN,
    input  logic [3:0]  C_BE_n,
    output logic [31:0] AD_OUT,
    output logic        AD_OE,
    output logic        TRDY_n,
    output logic        DEVSEL_n,
    output logic        CTL_OE
);
    typedef enum logic [2:0] {IDLE, BUSY, WRITE, READ_TA, READ, TURN} state_t;
    state_t      state_q;
    logic [31:0] mem_q [MEM_WORDS];
    logic [1:0]  idx_q;
    logic [1:0]  idx_d;
    logic        prev_idle_q;
    logic [31:0] ad_out_q;
    logic        ad_oe_q;
    logic        trdy_n_q;
    logic        devsel_n_q;
    logic        ctl_oe_q;
    logic [31:0] wr_word_d;
    logic        addr_phase;
    logic        hit;
    logic        done;
    assign addr_phase = !FRAME_n && prev_idle_q;
    assign hit        = (AD_IN[31:4] == BAR) && (C_BE_n[3:1] == 3'b011);
    assign done       = !IRDY_n && !trdy_n_q;
    assign idx_d      = idx_q + 2'd1;
    assign AD_OUT     = ad_out_q;
    assign AD_OE      = ad_oe_q;
    assign TRDY_n     = trdy_n_q;
    assign DEVSEL_n   = devsel_n_q;
    assign CTL_OE     = ctl_oe_q;
    // merge enabled byte lanes of the bus word into the addressed register
    always_comb begin
        wr_word_d = mem_q[idx_q];
        for (int k = 0; k < 4; k++)
            wr_word_d[8*k +: 8] = C_BE_n[k] ? mem_q[idx_q][8*k +: 8] : AD_IN[8*k +: 8];
    end
    // transaction FSM with registered bus outputs; reset releases all drivers at once
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            prev_idle_q <= 1'b0;
            ad_out_q    <= '0;
            ad_oe_q     <= 1'b0;
            trdy_n_q    <= 1'b1;
            devsel_n_q  <= 1'b1;
            ctl_oe_q    <= 1'b0;
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
        end else begin
            prev_idle_q <= FRAME_n && IRDY_n;
            case (state_q)
                IDLE: if (addr_phase) begin
                    if (hit) begin
                        idx_q      <= AD_IN[3:2];
                        ctl_oe_q   <= 1'b1;
                        devsel_n_q <= 1'b0;
                        trdy_n_q   <= !C_BE_n[0];
                        state_q    <= C_BE_n[0] ? WRITE : READ_TA;
                    end else begin
                        state_q <= BUSY;
                    end
                end
                BUSY: if (FRAME_n && IRDY_n) state_q <= IDLE;
                WRITE: if (done) begin
                    mem_q[idx_q] <= wr_word_d;
                    idx_q        <= idx_d;
                    if (FRAME_n) begin
                        state_q    <= TURN;
                        trdy_n_q   <= 1'b1;
                        devsel_n_q <= 1'b1;
                    end
                end
                READ_TA: begin
                    state_q  <= READ;
                    ad_oe_q  <= 1'b1;
                    trdy_n_q <= 1'b0;
                    ad_out_q <= mem_q[idx_q];
                end
                READ: if (done) begin
                    idx_q    <= idx_d;
                    ad_out_q <= FRAME_n ? 32'h0 : mem_q[idx_d];
                    if (FRAME_n) begin
                        state_q    <= TURN;
                        ad_oe_q    <= 1'b0;
                        trdy_n_q   <= 1'b1;
                        devsel_n_q <= 1'b1;
                    end
                end
                TURN: begin
                    state_q  <= IDLE;
                    ctl_oe_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pci_mem_target.sv
// tb_pci_mem_target: scenario bench with a memory model and a read-data scoreboard
module tb_pci_mem_target;
    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        FRAME_n = 1'b1;
    logic        IRDY_n = 1'b1;
    logic [31:0] AD_IN = '0;
    logic [3:0]  C_BE_n = 4'hF;
    logic [31:0] AD_OUT;
    logic        AD_OE;
    logic        TRDY_n;
    logic        DEVSEL_n;
    logic        CTL_OE;
    logic [3:0]  ctl;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] mdl [4];
    logic [31:0] exp_q [$];
    logic [31:0] wdat [4];
    logic [3:0]  wbe [4];

    // {CTL_OE, DEVSEL_n, TRDY_n, AD_OE}
    assign ctl = {CTL_OE, DEVSEL_n, TRDY_n, AD_OE};

    pci_mem_target dut (
        .CLK(CLK), .RST_n(RST_n), .FRAME_n(FRAME_n), .IRDY_n(IRDY_n),
        .AD_IN(AD_IN), .C_BE_n(C_BE_n), .AD_OUT(AD_OUT), .AD_OE(AD_OE),
        .TRDY_n(TRDY_n), .DEVSEL_n(DEVSEL_n), .CTL_OE(CTL_OE)
    );

    initial forever #5 CLK = ~CLK;

    // write transaction starting at a negedge; misses are expected to stay silent
    task automatic do_write(input logic [31:0] addr, input logic [3:0] cmd, input int n, input string tag);
        logic       hit;
        int         base;
        logic [3:0] want;
        hit  = (addr[31:4] == 28'h1) && (cmd == 4'b0111);
        base = int'(addr[3:2]);
        FRAME_n = 1'b0; IRDY_n = 1'b1; AD_IN = addr; C_BE_n = cmd;
        for (int p = 0; p < n; p++) begin
            @(negedge CLK);
            want = hit ? 4'b1000 : 4'b0110;
            n_tests++;
            if (ctl !== want) begin
                n_fail++;
                $display("FAIL %s_phase%0d_ctl: got %b want %b", tag, p, ctl, want);
            end
            IRDY_n = 1'b0; FRAME_n = (p == n - 1); AD_IN = wdat[p]; C_BE_n = wbe[p];
            if (hit)
                for (int k = 0; k < 4; k++)
                    if (!wbe[p][k]) mdl[(base + p) % 4][8*k +: 8] = wdat[p][8*k +: 8];
        end
        @(negedge CLK);
        want = hit ? 4'b1110 : 4'b0110;
        n_tests++;
        if (ctl !== want) begin
            n_fail++;
            $display("FAIL %s_turn_ctl: got %b want %b", tag, ctl, want);
        end
        FRAME_n = 1'b1; IRDY_n = 1'b1; AD_IN = '0; C_BE_n = 4'hF;
        @(negedge CLK);
        n_tests++;
        if (ctl !== 4'b0110) begin
            n_fail++;
            $display("FAIL %s_idle_ctl: got %b want 0110", tag, ctl);
        end
    endtask

    // read burst starting at a negedge; wait_p selects the phase that gets one IRDY_n wait state
    task automatic do_read(input logic [31:0] addr, input int n, input int wait_p, input string tag);
        int          base;
        logic [31:0] exp_v;
        base = int'(addr[3:2]);
        for (int p = 0; p < n; p++) exp_q.push_back(mdl[(base + p) % 4]);
        FRAME_n = 1'b0; IRDY_n = 1'b1; AD_IN = addr; C_BE_n = 4'b0110;
        @(negedge CLK);
        n_tests++;
        if (ctl !== 4'b1010 || AD_OUT !== 32'h0) begin
            n_fail++;
            $display("FAIL %s_ta: ctl %b ad %h want 1010 00000000", tag, ctl, AD_OUT);
        end
        AD_IN = '0; C_BE_n = 4'h0;
        for (int p = 0; p < n; p++) begin
            @(negedge CLK);
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            n_tests++;
            if (ctl !== 4'b1001 || AD_OUT !== exp_v) begin
                n_fail++;
                $display("FAIL %s_phase%0d: ctl %b ad %h want 1001 %h", tag, p, ctl, AD_OUT, exp_v);
            end
            if (p == wait_p) begin
                IRDY_n = 1'b1;
                @(negedge CLK);
                n_tests++;
                if (ctl !== 4'b1001 || AD_OUT !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s_wait%0d: ctl %b ad %h want 1001 %h", tag, p, ctl, AD_OUT, exp_v);
                end
            end
            IRDY_n = 1'b0; FRAME_n = (p == n - 1);
        end
        @(negedge CLK);
        n_tests++;
        if (ctl !== 4'b1110 || AD_OUT !== 32'h0) begin
            n_fail++;
            $display("FAIL %s_turn: ctl %b ad %h want 1110 00000000", tag, ctl, AD_OUT);
        end
        FRAME_n = 1'b1; IRDY_n = 1'b1; C_BE_n = 4'hF;
        @(negedge CLK);
        n_tests++;
        if (ctl !== 4'b0110) begin
            n_fail++;
            $display("FAIL %s_idle: ctl %b want 0110", tag, ctl);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        RST_n = 1'b0;
        repeat (2) @(negedge CLK);
        n_tests++;
        if (ctl !== 4'b0110 || AD_OUT !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_held: ctl %b ad %h want 0110 00000000", ctl, AD_OUT);
        end
        RST_n = 1'b1;
        @(negedge CLK);
        n_tests++;
        if (ctl !== 4'b0110 || AD_OUT !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_release: ctl %b ad %h want 0110 00000000", ctl, AD_OUT);
        end
    endtask

    task automatic test_partial_write();
        wdat[0] = 32'hBBBBBBBB; wbe[0] = 4'b1100;
        do_write(32'h10, 4'b0111, 1, "partial_wr");
        do_read(32'h10, 1, -1, "partial_rd");
    endtask

    task automatic test_single_write();
        wdat[0] = 32'hAAAAAAAA; wbe[0] = 4'b0000;
        do_write(32'h14, 4'b0111, 1, "single_wr");
        do_read(32'h14, 1, -1, "single_rd");
    endtask

    task automatic test_burst_write();
        wdat[0] = 32'h11223344; wbe[0] = 4'b0000;
        wdat[1] = 32'h55667788; wbe[1] = 4'b0101;
        wdat[2] = 32'h99AABBCC; wbe[2] = 4'b0011;
        wdat[3] = 32'hDDEEFF00; wbe[3] = 4'b1110;
        do_write(32'h18, 4'b0111, 4, "burst_wr");
    endtask

    task automatic test_burst_read();
        do_read(32'h1C, 3, 1, "burst_rd");
    endtask

    task automatic test_miss();
        wdat[0] = 32'hFFFFFFFF; wbe[0] = 4'b0000;
        wdat[1] = 32'hEEEEEEEE; wbe[1] = 4'b0000;
        do_write(32'h20, 4'b0111, 2, "miss_addr");
        do_write(32'h14, 4'b1100, 1, "miss_cmd");
        wdat[0] = 32'hCAFEF00D; wbe[0] = 4'b0000;
        do_write(32'h18, 4'b0111, 1, "after_miss");
        do_read(32'h10, 4, -1, "miss_rd");
    endtask

    task automatic test_back_to_back();
        wdat[0] = 32'h0BADF00D; wbe[0] = 4'b0000;
        wdat[1] = 32'h12345678; wbe[1] = 4'b1010;
        do_write(32'h1C, 4'b0111, 2, "b2b_wr");
        do_read(32'h18, 4, 3, "b2b_rd");
    endtask

    task automatic test_reset_mid();
        FRAME_n = 1'b0; IRDY_n = 1'b1; AD_IN = 32'h10; C_BE_n = 4'b0111;
        @(negedge CLK);
        IRDY_n = 1'b0; AD_IN = 32'h01010101; C_BE_n = 4'h0;
        @(negedge CLK);
        AD_IN = 32'h02020202;
        @(negedge CLK);
        n_tests++;
        if (ctl !== 4'b1000) begin
            n_fail++;
            $display("FAIL rstmid_active: ctl %b want 1000", ctl);
        end
        @(posedge CLK);
        #2 RST_n = 1'b0;
        #1;
        n_tests++;
        if (ctl !== 4'b0110 || AD_OUT !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_release: ctl %b ad %h want 0110 00000000", ctl, AD_OUT);
        end
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        exp_q.delete();
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
        n_tests++;
        if (ctl !== 4'b0110) begin
            n_fail++;
            $display("FAIL rstmid_noclaim: ctl %b want 0110", ctl);
        end
        FRAME_n = 1'b1; IRDY_n = 1'b1; AD_IN = '0; C_BE_n = 4'hF;
        @(negedge CLK);
        do_read(32'h10, 4, -1, "rstmid_rd");
    endtask

    initial begin
        test_reset();
        test_partial_write();
        test_single_write();
        test_burst_write();
        test_burst_read();
        test_miss();
        test_back_to_back();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
